// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus decoder and its watchdog.
// Holds the FSM state enum, default field widths and peripheral slot indices.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam int DEV_ADDR_W_DEF = 3;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int DATA_W_DEF     = 32;

    // Device slots 4..7 are reserved for future peripherals.
    localparam int EIC  = 0;
    localparam int BKD  = 1;
    localparam int UART = 2;
    localparam int STMR = 3;

endpackage

// File: rtl/io_bus_watchdog.sv
// ACCESS-phase timeout counter; instantiated by io_bus_decoder only when
// IO_BUS_TIMEOUT_EN is defined.
module io_bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_enable,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_enable && !ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the final allowed cycle still completes the transfer normally.
    assign expired = count_enable && !ready && (cnt_q == LAST);

endmodule

// File: rtl/io_bus_decoder.sv
// IO bus decoder / access sequencer: CPU data port to memory-mapped peripherals.
// Optional ACCESS timeout enabled by defining IO_BUS_TIMEOUT_EN.
module io_bus_decoder
    import io_bus_pkg::*;
#(
    parameter int DEV_ADDR_W = DEV_ADDR_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_DEV    = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 16
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           CpuReq,
    input  logic                           CpuWrite,
    input  logic [DEV_ADDR_W+REG_ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0]              CpuWrData,
    output logic [DATA_W-1:0]              CpuRdData,
    output logic                           CpuDone,
    output logic                           CpuError,
    output logic [NUM_DEV-1:0]             DevSel,
    output logic                           DevWrite,
    output logic [REG_ADDR_W-1:0]          DevRegAddr,
    output logic [DATA_W-1:0]              DevWrData,
    input  logic [NUM_DEV*DATA_W-1:0]      DevRdData,
    input  logic [NUM_DEV-1:0]             DevReady
);

    if (NUM_DEV < 1 || NUM_DEV > (1 << DEV_ADDR_W)) begin : g_bad_num_dev
        $error("io_bus_decoder: NUM_DEV out of range");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("io_bus_decoder: TIMEOUT must be at least 2");
    end

    localparam logic [DEV_ADDR_W:0] NUM_DEV_W = (DEV_ADDR_W + 1)'(NUM_DEV);

    state_e                state_q, state_d;
    logic [NUM_DEV-1:0]    sel_q, sel_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rd_q, rd_d;
    logic                  write_q, write_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic [DEV_ADDR_W-1:0] dev_field;
    logic                  mapped;
    logic [NUM_DEV-1:0]    sel_onehot;
    logic                  ready_sel;
    logic [DATA_W-1:0]     rd_sel;
    logic                  wd_clear;
    logic                  expired;

    assign dev_field = CpuAddr[DEV_ADDR_W+REG_ADDR_W-1:REG_ADDR_W];
    assign mapped    = ({1'b0, dev_field} < NUM_DEV_W);

    // The registered one-hot select doubles as the device index during ACCESS.
    always_comb begin
        sel_onehot = '0;
        rd_sel     = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            sel_onehot[i] = (dev_field == DEV_ADDR_W'(i));
            if (sel_q[i]) begin
                rd_sel = rd_sel | DevRdData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ready_sel = |(DevReady & sel_q);

`ifdef IO_BUS_TIMEOUT_EN
    io_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk         (Clock),
        .rst         (Reset),
        .clear       (wd_clear),
        .count_enable(state_q == ACCESS),
        .ready       (ready_sel),
        .expired     (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rd_d     = rd_q;
        write_d  = write_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        wd_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CpuReq) begin
                    write_d = CpuWrite;
                    reg_d   = CpuAddr[REG_ADDR_W-1:0];
                    wdata_d = CpuWrData;
                    if (mapped) begin
                        state_d  = ACCESS;
                        sel_d    = sel_onehot;
                        wd_clear = 1'b1;
                    end else begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end
                end
            end
            ACCESS: begin
                sel_d = sel_q;
                if (ready_sel) begin
                    state_d = RESP;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    rd_d    = write_q ? '0 : rd_sel;
                end else if (expired) begin
                    state_d = RESP;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            write_q <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            write_q <= write_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
        end
    end

    assign CpuRdData  = rd_q;
    assign CpuDone    = done_q;
    assign CpuError   = err_q;
    assign DevSel     = sel_q;
    assign DevWrite   = write_q;
    assign DevRegAddr = reg_q;
    assign DevWrData  = wdata_q;

endmodule
